// File: rtl/fft_pkg.sv
// Shared FFT datapath defaults, complex types and rounding helpers.
// Used by cmul_pipe and pipelined_butterfly.
package fft_pkg;

  localparam int DW_DEF = 16;
  localparam int TW_DEF = 16;

  typedef struct packed {
    logic signed [DW_DEF-1:0] re;
    logic signed [DW_DEF-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic signed [TW_DEF-1:0] re;
    logic signed [TW_DEF-1:0] im;
  } twid_t;

  // Half an LSB of a Q1.(tw-1) product, added before the shift
  function automatic int unsigned rnd_ofs(
    input int unsigned tw
  );
    return 32'd1 << (tw - 2);
  endfunction

  localparam int unsigned RND_OFS = rnd_ofs(TW_DEF);

endpackage

// File: rtl/cmul_pipe.sv
// Two-stage complex multiply w*b with rounding to DW+1 bits.
// Carries an opaque side payload in step with the data.
module cmul_pipe
  import fft_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int TW = TW_DEF,
  parameter int SW = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                in_valid,
  input  logic [2*DW-1:0]     b,
  input  logic [2*TW-1:0]     w,
  input  logic [SW-1:0]       in_side,
  output logic                out_valid,
  output logic signed [DW:0]  out_re,
  output logic signed [DW:0]  out_im,
  output logic [SW-1:0]       out_side
);

  localparam int PW = DW + TW;
  localparam logic signed [PW:0] RND =
    (PW+1)'(rnd_ofs(TW));

  logic signed [DW-1:0] br;
  logic signed [DW-1:0] bi;
  logic signed [TW-1:0] wr;
  logic signed [TW-1:0] wi;

  assign br = b[2*DW-1:DW];
  assign bi = b[DW-1:0];
  assign wr = w[2*TW-1:TW];
  assign wi = w[TW-1:0];

  logic                 v1;
  logic [SW-1:0]        s1;
  logic signed [PW-1:0] prr;
  logic signed [PW-1:0] pii;
  logic signed [PW-1:0] pri;
  logic signed [PW-1:0] pir;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      s1  <= '0;
      prr <= '0;
      pii <= '0;
      pri <= '0;
      pir <= '0;
    end else if (en) begin
      v1  <= in_valid;
      s1  <= in_side;
      prr <= PW'(br) * PW'(wr);
      pii <= PW'(bi) * PW'(wi);
      pri <= PW'(br) * PW'(wi);
      pir <= PW'(bi) * PW'(wr);
    end
  end

  logic signed [PW:0] dre;
  logic signed [PW:0] dim;
  logic signed [DW:0] rre;
  logic signed [DW:0] rim;

  assign dre = (PW+1)'(prr) - (PW+1)'(pii) + RND;
  assign dim = (PW+1)'(pri) + (PW+1)'(pir) + RND;
  assign rre = (DW+1)'(dre >>> (TW-1));
  assign rim = (DW+1)'(dim >>> (TW-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_side  <= '0;
    end else if (en) begin
      out_valid <= v1;
      out_re    <= rre;
      out_im    <= rim;
      out_side  <= s1;
    end
  end

endmodule

// File: rtl/pipelined_butterfly.sv
// Three-stage radix-2 butterfly Y=A+wB, Z=A-wB with valid/ready.
// Define BFLY_SAT_EN for saturation and sticky ovf; default wraps.
module pipelined_butterfly
  import fft_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int TW = TW_DEF
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] A,
  input  logic [2*DW-1:0] B,
  input  logic [2*TW-1:0] w,
  input  logic            scale,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] Y,
  output logic [2*DW-1:0] Z,
  output logic            ovf,
  input  logic            ovf_clr
);

  localparam int SW = 2*DW + 1;
  localparam int RW = DW + 2;

  logic en;

  assign en       = out_ready || !out_valid;
  assign in_ready = en;

  logic               mv;
  logic signed [DW:0] mre;
  logic signed [DW:0] mim;
  logic [SW-1:0]      mside;

  cmul_pipe #(
    .DW (DW),
    .TW (TW),
    .SW (SW)
  ) u_cmul (
    .clk       (Clk),
    .rst_n     (Rst_n),
    .en        (en),
    .in_valid  (in_valid),
    .b         (B),
    .w         (w),
    .in_side   ({scale, A}),
    .out_valid (mv),
    .out_re    (mre),
    .out_im    (mim),
    .out_side  (mside)
  );

  logic signed [DW-1:0] ar;
  logic signed [DW-1:0] ai;
  logic                 sc;

  assign sc = mside[SW-1];
  assign ar = mside[2*DW-1:DW];
  assign ai = mside[DW-1:0];

  // Optional halving rounds half-up before the shift
  function automatic logic signed [RW-1:0] fin(
    input logic signed [RW-1:0] s,
    input logic                 h
  );
    logic signed [RW-1:0] t;
    t = s + {{(RW-1){1'b0}}, 1'b1};
    return h ? (t >>> 1) : s;
  endfunction

  logic signed [RW-1:0] yre;
  logic signed [RW-1:0] yim;
  logic signed [RW-1:0] zre;
  logic signed [RW-1:0] zim;

  assign yre = fin(RW'(ar) + RW'(mre), sc);
  assign yim = fin(RW'(ai) + RW'(mim), sc);
  assign zre = fin(RW'(ar) - RW'(mre), sc);
  assign zim = fin(RW'(ai) - RW'(mim), sc);

`ifdef BFLY_SAT_EN
  localparam logic signed [RW-1:0] MAXV =
    {3'b000, {(DW-1){1'b1}}};
  localparam logic signed [RW-1:0] MINV =
    {3'b111, {(DW-1){1'b0}}};

  function automatic logic ovr(
    input logic signed [RW-1:0] s
  );
    return (s > MAXV) || (s < MINV);
  endfunction

  function automatic logic [DW-1:0] red(
    input logic signed [RW-1:0] s
  );
    if (s > MAXV)
      return MAXV[DW-1:0];
    else if (s < MINV)
      return MINV[DW-1:0];
    return DW'(s);
  endfunction
`else
  function automatic logic [DW-1:0] red(
    input logic signed [RW-1:0] s
  );
    return DW'(s);
  endfunction
`endif

  logic [2*DW-1:0] ynext;
  logic [2*DW-1:0] znext;

  assign ynext = {red(yre), red(yim)};
  assign znext = {red(zre), red(zim)};

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      out_valid <= 1'b0;
      Y         <= '0;
      Z         <= '0;
    end else if (en) begin
      out_valid <= mv;
      if (mv) begin
        Y <= ynext;
        Z <= znext;
      end
    end
  end

`ifdef BFLY_SAT_EN
  logic hit;
  logic y_ovf;

  assign hit = ovr(yre) | ovr(yim)
             | ovr(zre) | ovr(zim);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)
      y_ovf <= 1'b0;
    else if (en && mv)
      y_ovf <= hit;
  end

  // Set on the handshake that delivers a clipped result; set beats clear
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)
      ovf <= 1'b0;
    else
      ovf <= (ovf && !ovf_clr)
          || (out_valid && out_ready && y_ovf);
  end
`else
  logic unused_clr;

  assign unused_clr = ovf_clr;
  assign ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_butterfly.sv
// Self-checking bench for pipelined_butterfly (DW=TW=16).
// Behavioural model queue plus directed literal cases.
module tb_pipelined_butterfly;

  localparam int DW = 16;
  localparam int TW = 16;

  logic            Clk = 1'b0;
  logic            Rst_n = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2*DW-1:0] A = '0;
  logic [2*DW-1:0] B = '0;
  logic [2*TW-1:0] w = '0;
  logic            scale = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [2*DW-1:0] Y;
  logic [2*DW-1:0] Z;
  logic            ovf;
  logic            ovf_clr = 1'b0;

  always #5 Clk = ~Clk;

  pipelined_butterfly #(
    .DW (DW),
    .TW (TW)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .w         (w),
    .scale     (scale),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (Y),
    .Z         (Z),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  typedef struct {
    logic [2*DW-1:0] y;
    logic [2*DW-1:0] z;
    bit              ov;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   ndone = 0;

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, got, exp);
    end
  endtask

  function automatic longint sx(input longint v,
                                input int bits);
    longint m;
    longint r;
    m = longint'(1) <<< bits;
    r = v & (m - 1);
    if (r >= m / 2)
      r = r - m;
    return r;
  endfunction

  function automatic longint red(input longint s,
                                 inout bit ov);
    longint mx;
    longint mn;
    mx = (longint'(1) <<< (DW-1)) - 1;
    mn = -(longint'(1) <<< (DW-1));
`ifdef BFLY_SAT_EN
    if (s > mx) begin
      ov = 1'b1;
      return mx;
    end
    if (s < mn) begin
      ov = 1'b1;
      return mn;
    end
    return s;
`else
    if (s > mx || s < mn)
      return sx(s, DW);
    return s;
`endif
  endfunction

  // Exact arithmetic: product, round half-up at Q15, add/sub, scale
  function automatic exp_t model(input logic [2*DW-1:0] a,
                                 input logic [2*DW-1:0] b,
                                 input logic [2*TW-1:0] wt,
                                 input bit sc);
    longint ar, ai, br, bi, wr, wi, mr, mi, h;
    longint s[4];
    exp_t   e;
    bit     ov;
    ov = 1'b0;
    ar = longint'($signed(a[2*DW-1:DW]));
    ai = longint'($signed(a[DW-1:0]));
    br = longint'($signed(b[2*DW-1:DW]));
    bi = longint'($signed(b[DW-1:0]));
    wr = longint'($signed(wt[2*TW-1:TW]));
    wi = longint'($signed(wt[TW-1:0]));
    h  = longint'(1) <<< (TW-2);
    mr = sx((br*wr - bi*wi + h) >>> (TW-1), DW+1);
    mi = sx((br*wi + bi*wr + h) >>> (TW-1), DW+1);
    s[0] = ar + mr;
    s[1] = ai + mi;
    s[2] = ar - mr;
    s[3] = ai - mi;
    for (int i = 0; i < 4; i++) begin
      if (sc)
        s[i] = (s[i] + 1) >>> 1;
      s[i] = red(s[i], ov);
    end
    e.y  = {s[0][DW-1:0], s[1][DW-1:0]};
    e.z  = {s[2][DW-1:0], s[3][DW-1:0]};
    e.ov = ov;
    return e;
  endfunction

  logic            stalled_prev = 1'b0;
  logic [2*DW-1:0] py;
  logic [2*DW-1:0] pz;
  bit              ovf_m = 1'b0;

  always @(negedge Clk) begin
    exp_t e;
    bit   set;
    if (!Rst_n) begin
      q.delete();
      ovf_m        = 1'b0;
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_y", Y, py);
        chk("hold_z", Z, pz);
      end
      chk("ovf_track", ovf, ovf_m);
      set = 1'b0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", out_valid, 1'b0);
        end else begin
          e = q.pop_front();
          chk("y", Y, e.y);
          chk("z", Z, e.z);
          set = e.ov;
          ndone++;
        end
      end
`ifdef BFLY_SAT_EN
      ovf_m = (ovf_m && !ovf_clr) || set;
`else
      ovf_m = 1'b0;
`endif
      stalled_prev = out_valid && !out_ready;
      py = Y;
      pz = Z;
      if (in_valid && in_ready)
        q.push_back(model(A, B, w, scale));
    end
  end

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic directed(input string nm,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input logic [31:0] wt,
                          input bit sc,
                          input logic [31:0] ey,
                          input logic [31:0] ez,
                          input bit eov);
    cyc();
    A = a;
    B = b;
    w = wt;
    scale = sc;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    @(negedge Clk);
    chk({nm, "_early"}, out_valid, 1'b0);
    cyc();
    @(negedge Clk);
    chk({nm, "_valid"}, out_valid, 1'b1);
    chk({nm, "_y"}, Y, ey);
    chk({nm, "_z"}, Z, ez);
    cyc();
    @(negedge Clk);
    chk({nm, "_ovf"}, ovf, eov);
  endtask

  function automatic logic [15:0] pick();
    logic [15:0] c[4];
    c[0] = 16'h8000;
    c[1] = 16'h7FFF;
    c[2] = 16'h0000;
    c[3] = 16'hFFFF;
    if ($urandom_range(0, 3) == 0)
      return c[$urandom_range(0, 3)];
    return 16'($urandom);
  endfunction

  int sent;
  int base;
  bit sat;

  initial begin
`ifdef BFLY_SAT_EN
    sat = 1'b1;
`else
    sat = 1'b0;
`endif
    #1;
    Rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_y", Y, 32'h0);
    chk("rst_z", Z, 32'h0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    repeat (2) cyc();
    Rst_n = 1'b1;
    @(negedge Clk);
    chk("rel_in_ready", in_ready, 1'b1);

    directed("r030", 32'h10000000, 32'h20000000,
             32'h7FFF0000, 1'b0,
             32'h30000000, 32'hF0000000, 1'b0);
    directed("r031", 32'h10000000, 32'h20000000,
             32'h7FFF0000, 1'b1,
             32'h18000000, 32'hF8000000, 1'b0);
    directed("r032", 32'h00000000, 32'h20000000,
             32'h00007FFF, 1'b0,
             32'h00002000, 32'h0000E000, 1'b0);
    directed("r033", 32'h70000000, 32'h70000000,
             32'h7FFF0000, 1'b0,
             sat ? 32'h7FFF0000 : 32'hDFFF0000,
             32'h00010000, sat);
    cyc();
    @(negedge Clk);
    chk("ovf_sticky", ovf, sat);
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    @(negedge Clk);
    chk("ovf_cleared", ovf, 1'b0);

    // Back-to-back stream with a downstream stall on cycles 4-8
    sent = 0;
    base = ndone;
    for (int c = 1; c <= 20; c++) begin
      cyc();
      out_ready = !(c >= 4 && c <= 8);
      in_valid = (sent < 6);
      A = {pick(), pick()};
      B = {pick(), pick()};
      w = {pick(), pick()};
      scale = 1'($urandom);
      @(negedge Clk);
      if (c >= 4 && c <= 8)
        chk("stall_in_ready", in_ready, 1'b0);
      if (in_valid && in_ready)
        sent++;
    end
    cyc();
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stall_delivered", ndone - base, 6);

    // Two in flight, reset while the first sits on the output
    cyc();
    A = 32'h01230456;
    B = 32'h11112222;
    w = 32'h40000000;
    in_valid = 1'b1;
    cyc();
    A = 32'h0AAA0BBB;
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("pre_rst_valid", out_valid, 1'b1);
    Rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_y", Y, 32'h0);
    cyc();
    Rst_n = 1'b1;
    @(negedge Clk);
    chk("post_rst_ready", in_ready, 1'b1);
    directed("r035", 32'h10000000, 32'h20000000,
             32'h7FFF0000, 1'b0,
             32'h30000000, 32'hF0000000, 1'b0);

    for (int i = 0; i < 400; i++) begin
      cyc();
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      ovf_clr = ($urandom_range(0, 9) == 0);
      A = {pick(), pick()};
      B = {pick(), pick()};
      w = {pick(), pick()};
      scale = 1'($urandom);
    end

    cyc();
    in_valid = 1'b0;
    out_ready = 1'b1;
    ovf_clr = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (q.size() == 0 && !out_valid)
        break;
      cyc();
    end
    @(negedge Clk);
    chk("drain", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, 1 expected 0");
    $fatal(1);
  end

endmodule
